// File: rtl/dmem_responder.sv
// Single-ported data memory responder for a RISC-V load/store unit.
// Requests are accepted in IDLE, take two ACCESS cycles, then are held in RESP.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic          phase_q;
  logic          wren_q;
  logic [1:0]    lane_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   rdword_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [29:0]   off_w;
  logic          range_err;
  logic          align_err;
  logic          err_d;
  logic [AW-1:0] idx_d;

  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   lane_word;
  logic [31:0]   ld_data;

  assign req_ready = (state_q == IDLE);

  // Request decode, evaluated on the incoming fields at acceptance.
  assign off_w = 30'((req_addr - BASE_ADDR) >> 2);
  assign idx_d = off_w[AW-1:0];

  always_comb begin
    range_err = (req_addr < BASE_ADDR) ||
                ({2'b00, off_w} >= 32'(DEPTH_WORDS));
    align_err = 1'b0;
    unique case (req_size)
      2'b00:   align_err = 1'b0;
      2'b01:   align_err = req_addr[0];
      2'b10:   align_err = (req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    err_d = range_err || align_err;
  end

  // Store lanes and replicated data so any enabled lane sees its bytes.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    unique case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << lane_q;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = lane_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = wdata_q;
      end
    endcase
  end

  // Read in the first ACCESS cycle, write in the second; reset cancels a write.
  assign mem_re = (state_q == ACCESS) && !phase_q && !wren_q && !err_q;
  assign mem_we = (state_q == ACCESS) && phase_q && wren_q && !err_q &&
                  !reset;

  always_ff @(posedge clk) begin
    if (mem_re) begin
      rdword_q <= mem_q[idx_q];
    end
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    lane_word = rdword_q >> {lane_q, 3'b000};
    ld_data   = rdword_q;
    unique case (size_q)
      2'b00: begin
        ld_data = uns_q ? {24'd0, lane_word[7:0]}
                        : {{24{lane_word[7]}}, lane_word[7:0]};
      end
      2'b01: begin
        ld_data = uns_q ? {16'd0, lane_word[15:0]}
                        : {{16{lane_word[15]}}, lane_word[15:0]};
      end
      default: begin
        ld_data = rdword_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wren_q  <= req_wren;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= err_d;
            idx_q   <= idx_d;
            phase_q <= 1'b0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
          end else begin
            phase_q   <= 1'b0;
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= err_q;
            rsp_rdata <= (err_q || wren_q) ? 32'd0 : ld_data;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
